// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
//   UART_CLKS_PER_TICK : default sysclk cycles per oversample tick (50 MHz, 9600 baud)
//   UART_OVERSAMPLE    : default oversample ticks per serial bit
//   UART_DATA_W        : data bits per frame
//   uart_tx_state_t    : transmitter state encoding (PARITY is used only when
//                        UART_TX_PARITY_EN is defined)
package uart_pkg;

   localparam int UART_CLKS_PER_TICK = 326;
   localparam int UART_OVERSAMPLE    = 16;
   localparam int UART_DATA_W        = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_tx_state_t;

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick divider. Counts 0..CLKS_PER_TICK-1 and wraps, producing a
// one-cycle enable on the last count. A synchronous clear holds the count at 0.
// Ports:
//   i_clk   : system clock
//   i_rst_n : asynchronous active-low reset
//   i_clr   : synchronous clear; counter held at 0 and no tick while high
//   o_tick  : one-cycle oversample enable
module uart_tick_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_TICK = UART_CLKS_PER_TICK
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   output logic o_tick
);

   localparam int CNT_W = 9;

   logic [CNT_W-1:0] r_cnt;
   logic             w_last;

   assign w_last = (r_cnt == CNT_W'(CLKS_PER_TICK - 1));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || w_last) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_tick = w_last & ~i_clr;

endmodule

// File: rtl/uart_tx_os.sv
// 8-bit UART transmitter on a shared oversample timebase.
// Frame: start(0), 8 data bits LSB first, optional even parity, STOP_BITS stop(1).
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
// Handshake: a byte is accepted on the rising sysclk edge where tx_valid and
// tx_ready are both 1; tx_valid while tx_ready is 0 is ignored (no queueing).
// Ports:
//   sysclk      : system clock
//   rst_n       : asynchronous active-low reset
//   tx_data     : byte to send, sampled on accept
//   tx_valid    : byte available
//   tx_ready    : idle, able to accept a byte
//   tx_busy     : frame in progress (complement of tx_ready)
//   txd         : registered serial output, idle high
//   o_dbg_state : current FSM state
module uart_tx_os
   import uart_pkg::*;
#(
   parameter int CLKS_PER_TICK = UART_CLKS_PER_TICK,
   parameter int OVERSAMPLE    = UART_OVERSAMPLE,
   parameter int STOP_BITS     = 1
) (
   input  logic                   sysclk,
   input  logic                   rst_n,
   input  logic [UART_DATA_W-1:0] tx_data,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic                   tx_busy,
   output logic                   txd,
   output uart_tx_state_t         o_dbg_state
);

   localparam int OS_W = $clog2(OVERSAMPLE);

   uart_tx_state_t         r_state, w_state_nxt;
   logic [UART_DATA_W-1:0] r_shift, w_shift_nxt;
   logic [2:0]             r_bit_idx, w_bit_idx_nxt;
   logic                   r_stop_cnt, w_stop_cnt_nxt;
   logic [OS_W-1:0]        r_os_cnt;
   logic                   r_txd, w_txd_nxt;
   logic                   w_tick;
   logic                   w_bit_end;
   logic                   w_accept;
   logic                   w_last_stop;
`ifdef UART_TX_PARITY_EN
   logic                   r_parity;
`endif

   assign w_accept    = tx_valid & (r_state == IDLE);
   assign w_bit_end   = w_tick & (r_os_cnt == OS_W'(OVERSAMPLE - 1));
   assign w_last_stop = (STOP_BITS == 1) ? 1'b1 : r_stop_cnt;

   // Divider is cleared whenever idle, so the first tick of a frame always
   // lands a full CLKS_PER_TICK after the accept edge.
   uart_tick_gen #(
      .CLKS_PER_TICK(CLKS_PER_TICK)
   ) u_tick_gen (
      .i_clk  (sysclk),
      .i_rst_n(rst_n),
      .i_clr  (r_state == IDLE),
      .o_tick (w_tick)
   );

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_os_cnt <= '0;
      end else if ((r_state == IDLE) || w_bit_end) begin
         r_os_cnt <= '0;
      end else if (w_tick) begin
         r_os_cnt <= r_os_cnt + 1'b1;
      end
   end

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_shift    <= '0;
         r_bit_idx  <= '0;
         r_stop_cnt <= 1'b0;
         r_txd      <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_shift    <= w_shift_nxt;
         r_bit_idx  <= w_bit_idx_nxt;
         r_stop_cnt <= w_stop_cnt_nxt;
         r_txd      <= w_txd_nxt;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         r_parity <= 1'b0;
      end else if (w_accept) begin
         r_parity <= ^tx_data;
      end
   end
`endif

   always_comb begin
      w_state_nxt    = r_state;
      w_shift_nxt    = r_shift;
      w_bit_idx_nxt  = r_bit_idx;
      w_stop_cnt_nxt = r_stop_cnt;
      case (r_state)
         IDLE: begin
            if (w_accept) begin
               w_state_nxt    = START;
               w_shift_nxt    = tx_data;
               w_bit_idx_nxt  = '0;
               w_stop_cnt_nxt = 1'b0;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_state_nxt   = DATA;
               w_bit_idx_nxt = '0;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_shift_nxt   = r_shift >> 1;
               w_bit_idx_nxt = r_bit_idx + 1'b1;
               if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  w_state_nxt = PARITY;
`else
                  w_state_nxt = STOP;
`endif
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (w_bit_end) begin
               w_state_nxt = STOP;
            end
         end
`endif
         STOP: begin
            if (w_bit_end) begin
               if (w_last_stop) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_stop_cnt_nxt = 1'b1;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // txd is registered from the next state, so the start bit appears the
   // cycle right after the accept edge.
   always_comb begin
      w_txd_nxt = 1'b1;
      case (w_state_nxt)
         START:   w_txd_nxt = 1'b0;
         DATA:    w_txd_nxt = w_shift_nxt[0];
`ifdef UART_TX_PARITY_EN
         PARITY:  w_txd_nxt = r_parity;
`endif
         default: w_txd_nxt = 1'b1;
      endcase
   end

   assign txd         = r_txd;
   assign tx_ready    = (r_state == IDLE);
   assign tx_busy     = ~tx_ready;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_os.sv
// Bench for uart_tx_os with CLKS_PER_TICK=4, OVERSAMPLE=16 (64-cycle bit).
// Honours UART_TX_PARITY_EN when the bench and design are built with it.
module tb_uart_tx_os;
   import uart_pkg::*;

   localparam int CPT       = 4;
   localparam int OS        = 16;
   localparam int STOP_BITS = 1;
   localparam int BIT_CYC   = CPT * OS;
`ifdef UART_TX_PARITY_EN
   localparam int PAR_BITS  = 1;
`else
   localparam int PAR_BITS  = 0;
`endif
   localparam int FRAME_BITS = 9 + PAR_BITS + STOP_BITS;
   localparam int FRAME_CYC  = FRAME_BITS * BIT_CYC;

   logic           sysclk = 1'b0;
   logic           rst_n  = 1'b0;
   logic [7:0]     tx_data = 8'h00;
   logic           tx_valid = 1'b0;
   logic           tx_ready;
   logic           tx_busy;
   logic           txd;
   uart_tx_state_t dbg_state;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_os #(
      .CLKS_PER_TICK(CPT),
      .OVERSAMPLE   (OS),
      .STOP_BITS    (STOP_BITS)
   ) dut (
      .sysclk     (sysclk),
      .rst_n      (rst_n),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_busy    (tx_busy),
      .txd        (txd),
      .o_dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 sysclk = ~sysclk;

   // ---------------- check helper ----------------
   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // exp_q holds the line level for every cycle of a frame still to come.
   logic [0:0] exp_q[$];
   logic       exp_txd  = 1'b1;
   logic       exp_busy = 1'b0;

   function automatic void push_frame(input logic [7:0] d);
      for (int c = 0; c < BIT_CYC; c++) exp_q.push_back(1'b0);
      for (int b = 0; b < 8; b++)
         for (int c = 0; c < BIT_CYC; c++) exp_q.push_back(d[b]);
`ifdef UART_TX_PARITY_EN
      for (int c = 0; c < BIT_CYC; c++) exp_q.push_back(^d);
`endif
      for (int c = 0; c < STOP_BITS * BIT_CYC; c++) exp_q.push_back(1'b1);
   endfunction

   always @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         exp_q.delete();
         exp_txd  <= 1'b1;
         exp_busy <= 1'b0;
      end else if (exp_q.size() != 0) begin
         exp_txd  <= exp_q.pop_front();
         exp_busy <= 1'b1;
      end else if (tx_valid && !exp_busy) begin
         push_frame(tx_data);
         exp_txd  <= exp_q.pop_front();
         exp_busy <= 1'b1;
      end else begin
         exp_txd  <= 1'b1;
         exp_busy <= 1'b0;
      end
   end

   // ---------------- scoreboard compare, every cycle ----------------
   always @(negedge sysclk) begin
      check("txd",      {7'd0, txd},      {7'd0, exp_txd});
      check("tx_ready", {7'd0, tx_ready}, {7'd0, ~exp_busy});
      check("tx_busy",  {7'd0, tx_busy},  {7'd0, exp_busy});
   end

   // ---------------- driver tasks ----------------
   task automatic wait_negs(input int n);
      repeat (n) @(negedge sysclk);
   endtask

   // Returns at the negedge right after the accept edge.
   task automatic send_accept(input logic [7:0] d);
      @(negedge sysclk);
      tx_data  = d;
      tx_valid = 1'b1;
      @(posedge sysclk);
      @(negedge sysclk);
      tx_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n = 0;
      while (tx_ready !== 1'b1 && n < max_cyc) begin
         @(negedge sysclk);
         n++;
      end
      check("idle_timeout", {7'd0, tx_ready}, 8'd1);
   endtask

   // Walk one frame mid-bit against a hand-written bit table, then check
   // tx_ready around the end of the frame.
   task automatic walk_frame(input logic [7:0] d, input logic [10:0] bits);
      send_accept(d);
      check("lit_first_txd", {7'd0, txd}, 8'd0);
      check("lit_first_busy", {7'd0, tx_busy}, 8'd1);
      wait_negs(BIT_CYC / 2);
      for (int b = 0; b < FRAME_BITS; b++) begin
         if (b != 0) wait_negs(BIT_CYC);
         check("lit_bit", {7'd0, txd}, {7'd0, bits[b]});
      end
      wait_negs(BIT_CYC / 2 - 1);
      check("lit_ready_last", {7'd0, tx_ready}, 8'd0);
      wait_negs(1);
      check("lit_ready_back", {7'd0, tx_ready}, 8'd1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [10:0] lit;
      int          low0;

      // reset idle
      rst_n = 1'b0;
      wait_negs(5);
      #2 rst_n = 1'b1;
      wait_negs(1);
      check("rst_txd", {7'd0, txd}, 8'd1);
      check("rst_ready", {7'd0, tx_ready}, 8'd1);
      check("rst_state", {5'd0, dbg_state}, {5'd0, IDLE});
      wait_negs(200);

      // single byte with literal bit tables
`ifdef UART_TX_PARITY_EN
      lit = 11'b11000001110;          // 0x07: start, 1,1,1,0,0,0,0,0, par 1, stop
      walk_frame(8'h07, lit);
      send_accept(8'h03);
      wait_negs(9 * BIT_CYC + BIT_CYC / 2 - 1);
      check("par_03", {7'd0, txd}, 8'd0);
      wait_idle(FRAME_CYC + 10);
`else
      lit = 11'b01101001010;          // 0xA5: start, 1,0,1,0,0,1,0,1, stop
      walk_frame(8'hA5, lit);
`endif
      wait_negs(3);

      // back-to-back with tx_valid held: 0x00 then 0xFF
      low0 = (9 + PAR_BITS) * BIT_CYC;  // 0x00 has even parity 0
      @(negedge sysclk);
      tx_data  = 8'h00;
      tx_valid = 1'b1;
      @(posedge sysclk);
      @(negedge sysclk);
      tx_data = 8'hFF;
      wait_negs(low0 - 1);
      check("b2b_low_end", {7'd0, txd}, 8'd0);
      wait_negs(1);
      check("b2b_stop", {7'd0, txd}, 8'd1);
      wait_negs(FRAME_CYC - low0 - 1);
      check("b2b_stop_last", {7'd0, txd}, 8'd1);
      wait_negs(1);
      check("b2b_gap_ready", {7'd0, tx_ready}, 8'd1);
      check("b2b_gap_txd", {7'd0, txd}, 8'd1);
      wait_negs(1);
      check("b2b_start2", {7'd0, txd}, 8'd0);
      tx_valid = 1'b0;
      wait_negs(BIT_CYC + BIT_CYC / 2);
      check("b2b_ff_bit0", {7'd0, txd}, 8'd1);
      wait_idle(FRAME_CYC + 10);
      wait_negs(2);

      // ignored valid while busy
      send_accept(8'h96);
      wait_negs(99);
      tx_data  = 8'h3C;
      tx_valid = 1'b1;
      @(negedge sysclk);
      tx_valid = 1'b0;
      wait_idle(FRAME_CYC + 10);
      wait_negs(100);
      check("ign_no_extra", {7'd0, tx_ready}, 8'd1);

      // reset mid-frame
      send_accept(8'h00);
      wait_negs(299);
      #2 rst_n = 1'b0;
      #1 check("async_rst_txd", {7'd0, txd}, 8'd1);
      wait_negs(3);
      #2 rst_n = 1'b1;
      wait_negs(1);
      check("rst_mid_ready", {7'd0, tx_ready}, 8'd1);
      send_accept(8'h5A);
      check("rst_mid_start", {7'd0, txd}, 8'd0);
      wait_idle(FRAME_CYC + 10);

      // randomized traffic, including valids that land while busy
      for (int i = 0; i < 20000; i++) begin
         @(negedge sysclk);
         tx_valid = ($urandom_range(0, 9) == 0);
         tx_data  = 8'($urandom);
      end
      @(negedge sysclk);
      tx_valid = 1'b0;
      wait_idle(FRAME_CYC + 10);
      wait_negs(5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
